// File: rtl/raifes_pcpi_muldiv_if.sv
// PCPI coprocessor bus: the core drives instruction and operands, the coprocessor
// answers with wait/ready/wr and the result word.
interface raifes_pcpi_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/raifes_pcpi_muldiv.sv
// RV32M/RV64M multiply/divide coprocessor on PCPI. Multiplies retire MUL_STEP bits of
// |rs2| per cycle with a shift-add datapath on magnitudes; divides are restoring, one
// quotient bit per cycle. Signs are applied once at the end.
module raifes_pcpi_muldiv #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 8
) (
  input logic                  clk,
  input logic                  reset,
  raifes_pcpi_muldiv_if.slave  pcpi_io
);

  localparam int unsigned NSteps  = XLEN / MUL_STEP;
  localparam int unsigned CntW    = $clog2(XLEN);
  localparam int unsigned ShW     = $clog2(2 * XLEN);
  localparam int unsigned StepLog = $clog2(MUL_STEP);
  localparam int unsigned PartW   = XLEN + MUL_STEP;

  localparam logic [CntW-1:0] MulLast = CntW'(NSteps - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  if (!((XLEN == 32) || (XLEN == 64)) || (MUL_STEP == 0) || ((XLEN % MUL_STEP) != 0) ||
      ((MUL_STEP & (MUL_STEP - 1)) != 0)) begin : g_bad_params
    $error("raifes_pcpi_muldiv: illegal XLEN/MUL_STEP combination");
  end

  logic [1:0]        state_q, state_d;
  logic              guard_q, guard_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;       // |rs1|, then dividend/quotient shift register
  logic [XLEN-1:0]   b_q, b_d;       // |rs2|, consumed LSB-first by the multiplier
  logic [XLEN-1:0]   res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // product accumulator; low half is the remainder
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic            hit, accept;
  logic [2:0]      f3;
  logic            sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;

  logic [PartW-1:0]  partial;
  logic [ShW-1:0]    shamt;
  logic [2*XLEN-1:0] acc_sum, mul_prod;
  logic [XLEN-1:0]   mul_res;

  logic [XLEN:0]   trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, quo_next, div_pick, div_res;

  // Decode the presented instruction and prepare operand magnitudes.
  always_comb begin
    f3       = pcpi_io.pcpi_insn[14:12];
    hit      = (pcpi_io.pcpi_insn[6:0] == 7'b0110011) &&
               (pcpi_io.pcpi_insn[31:25] == 7'b0000001);
    accept   = (state_q == StIdle) && pcpi_io.pcpi_valid && hit && !guard_q;
    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 for MUL, MULH, DIV, REM.
    sgn1     = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    sgn2     = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    s1       = sgn1 && pcpi_io.pcpi_rs1[XLEN-1];
    s2       = sgn2 && pcpi_io.pcpi_rs2[XLEN-1];
    // Negating the most negative value yields 2^(XLEN-1), which is its correct magnitude.
    mag1     = s1 ? -pcpi_io.pcpi_rs1 : pcpi_io.pcpi_rs1;
    mag2     = s2 ? -pcpi_io.pcpi_rs2 : pcpi_io.pcpi_rs2;
    div_zero = (pcpi_io.pcpi_rs2 == '0);
    div_ovf  = ((f3 == 3'd4) || (f3 == 3'd6)) && (pcpi_io.pcpi_rs1 == MinNeg) &&
               (pcpi_io.pcpi_rs2 == '1);
  end

  // Multiply step and restoring-divide step datapaths.
  always_comb begin
    partial  = PartW'(a_q) * PartW'(b_q[MUL_STEP-1:0]);
    shamt    = ShW'(cnt_q) << StepLog;
    acc_sum  = acc_q + ((2 * XLEN)'(partial) << shamt);
    mul_prod = neg_q ? -acc_sum : acc_sum;
    mul_res  = (op_q == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // Top bit of the XLEN+1 bit difference is the borrow.
    trial    = {acc_q[XLEN-1:0], a_q[XLEN-1]} - {1'b0, b_q};
    q_bit    = ~trial[XLEN];
    rem_next = q_bit ? trial[XLEN-1:0] : {acc_q[XLEN-2:0], a_q[XLEN-1]};
    quo_next = {a_q[XLEN-2:0], q_bit};
    div_pick = op_q[1] ? rem_next : quo_next;
    div_res  = neg_q ? -div_pick : div_pick;
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    op_d    = op_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        guard_d = 1'b0;
        if (accept) begin
          op_d  = f3;
          a_d   = mag1;
          b_d   = mag2;
          acc_d = '0;
          cnt_d = '0;
          if (!f3[2]) begin
            neg_d   = s1 ^ s2;
            state_d = StMul;
          end else begin
            // Remainder takes the dividend's sign, quotient the XOR of both.
            neg_d = f3[1] ? s1 : (s1 ^ s2);
            if (div_zero) begin
              res_d   = f3[1] ? pcpi_io.pcpi_rs1 : '1;
              state_d = StDone;
            end else if (div_ovf) begin
              res_d   = f3[1] ? '0 : pcpi_io.pcpi_rs1;
              state_d = StDone;
            end else begin
              state_d = StDiv;
            end
          end
        end
      end
      StMul: begin
        acc_d = acc_sum;
        b_d   = b_q >> MUL_STEP;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MulLast) begin
          res_d   = mul_res;
          state_d = StDone;
        end
      end
      StDiv: begin
        acc_d = {{XLEN{1'b0}}, rem_next};
        a_d   = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DivLast) begin
          res_d   = div_res;
          state_d = StDone;
        end
      end
      StDone: begin
        // The core's valid lags ready by a cycle; ignore the first IDLE cycle after this.
        guard_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      guard_q <= 1'b0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pcpi_io.pcpi_ready = (state_q == StDone);
  assign pcpi_io.pcpi_wr    = (state_q == StDone);
  assign pcpi_io.pcpi_wait  = (state_q == StMul) || (state_q == StDiv);
  assign pcpi_io.pcpi_rd    = (state_q == StDone) ? res_q : '0;

endmodule

// File: tb/tb_raifes_pcpi_muldiv.sv
// Scoreboard bench for raifes_pcpi_muldiv: a 32-bit/radix-256 instance and a
// 64-bit/radix-2 instance, checked against a 128-bit arithmetic reference model.
module tb_raifes_pcpi_muldiv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  raifes_pcpi_muldiv_if #(.XLEN(32)) if32 ();
  raifes_pcpi_muldiv_if #(.XLEN(64)) if64 ();

  raifes_pcpi_muldiv #(.XLEN(32), .MUL_STEP(8)) dut32 (
    .clk     (clk),
    .reset   (reset),
    .pcpi_io (if32)
  );

  raifes_pcpi_muldiv #(.XLEN(64), .MUL_STEP(1)) dut64 (
    .clk     (clk),
    .reset   (reset),
    .pcpi_io (if64)
  );

  typedef struct {
    logic [63:0] rd;
    int          due;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit infl[2];
  int infl_start[2];
  int infl_due[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] xmask(input int xlen);
    return (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] xmin(input int xlen);
    return (xlen == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
  endfunction

  function automatic logic signed [127:0] ext(input int xlen, input bit sgn,
                                              input logic [63:0] v);
    if (xlen == 32) return sgn ? {{96{v[31]}}, v[31:0]} : {96'd0, v[31:0]};
    return sgn ? {{64{v[63]}}, v} : {64'd0, v};
  endfunction

  function automatic bit rs1_signed(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
  endfunction

  function automatic bit rs2_signed(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
  endfunction

  function automatic bit div_special(input int xlen, input logic [2:0] f3,
                                     input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m;
    m = xmask(xlen);
    if (f3 < 3'd4) return 1'b0;
    if ((b & m) == 64'd0) return 1'b1;
    return rs1_signed(f3) && ((a & m) == xmin(xlen)) && ((b & m) == m);
  endfunction

  // Reference result from exact wide arithmetic plus the RISC-V special-case rules.
  function automatic logic [63:0] model(input int xlen, input logic [2:0] f3,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] x, y, p, q, r;
    logic [63:0] m;
    m = xmask(xlen);
    x = ext(xlen, rs1_signed(f3), a);
    y = ext(xlen, rs2_signed(f3), b);
    if (f3 < 3'd4) begin
      p = x * y;
      if (f3 == 3'd0) return p[63:0] & m;
      p = p >> xlen;
      return p[63:0] & m;
    end
    if ((b & m) == 64'd0) begin
      q = -128'sd1;
      r = x;
    end else if (div_special(xlen, f3, a, b)) begin
      q = x;
      r = 128'sd0;
    end else begin
      q = x / y;
      r = x % y;
    end
    return (f3[1] ? r[63:0] : q[63:0]) & m;
  endfunction

  function automatic int latency(input int xlen, input int step, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] b);
    if (f3 < 3'd4) return xlen / step + 1;
    if (div_special(xlen, f3, a, b)) return 1;
    return xlen + 1;
  endfunction

  function automatic logic [63:0] rand_opnd(input int xlen);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = xmask(xlen);
      3: v = xmin(xlen);
      4: v = xmin(xlen) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & xmask(xlen);
  endfunction

  task automatic fail_line(input string what, input int sel, input logic [63:0] got,
                           input logic [63:0] want);
    n_bad++;
    $display("FAIL %s dut%0d cyc=%0d: got %h, want %h", what, sel, cyc, got, want);
  endtask

  // Per-cycle monitor: wait/wr/rd shape every cycle, scoreboard pop on each ready pulse.
  task automatic check_out(input int sel, input logic ready, input logic wr, input logic wt,
                           input logic [63:0] rd);
    bit ew;
    exp_t e;
    int have;
    ew = infl[sel] && (cyc > infl_start[sel]) && (cyc < infl_due[sel]);
    n_vec++;
    if (wt !== ew) fail_line("wait", sel, 64'(wt), 64'(ew));
    n_vec++;
    if (wr !== ready) fail_line("wr_vs_ready", sel, 64'(wr), 64'(ready));
    if (ready !== 1'b1) begin
      n_vec++;
      if (rd !== 64'd0) fail_line("rd_idle", sel, rd, 64'd0);
    end else begin
      have = (sel == 0) ? exp_q0.size() : exp_q1.size();
      n_vec++;
      if (have == 0) begin
        fail_line("spurious_ready", sel, 64'd1, 64'd0);
      end else begin
        e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (rd !== e.rd) fail_line("rd", sel, rd, e.rd);
        n_vec++;
        if (cyc != e.due) fail_line("latency", sel, 64'(cyc), 64'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_out(0, if32.pcpi_ready, if32.pcpi_wr, if32.pcpi_wait, 64'(if32.pcpi_rd));
      check_out(1, if64.pcpi_ready, if64.pcpi_wr, if64.pcpi_wait, if64.pcpi_rd);
    end
  end

  task automatic drive(input int sel, input logic v, input logic [31:0] insn,
                       input logic [63:0] a, input logic [63:0] b);
    if (sel == 0) begin
      if32.pcpi_valid = v;
      if32.pcpi_insn  = insn;
      if32.pcpi_rs1   = a[31:0];
      if32.pcpi_rs2   = b[31:0];
      if64.pcpi_valid = 1'b0;
    end else begin
      if64.pcpi_valid = v;
      if64.pcpi_insn  = insn;
      if64.pcpi_rs1   = a;
      if64.pcpi_rs2   = b;
      if32.pcpi_valid = 1'b0;
    end
  endtask

  task automatic idle();
    if32.pcpi_valid = 1'b0;
    if64.pcpi_valid = 1'b0;
  endtask

  function automatic logic [31:0] m_insn(input logic [2:0] f3);
    return {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
  endfunction

  // Issue one op at negedge+1, hold valid until ready, optionally one cycle beyond it,
  // and return at negedge+1 of cycle L+2.
  task automatic run_op(input int sel, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input bit hold, input logic [63:0] want);
    int   xlen;
    int   lat;
    int   c0;
    bit   seen;
    exp_t e;
    xlen = (sel == 0) ? 32 : 64;
    lat  = latency(xlen, (sel == 0) ? 8 : 1, f3, a, b);
    c0   = cyc;
    e.rd  = want;
    e.due = c0 + lat;
    if (sel == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    infl_start[sel] = c0;
    infl_due[sel]   = c0 + lat;
    infl[sel]       = 1'b1;
    drive(sel, 1'b1, m_insn(f3), a, b);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (sel == 0) ? (if32.pcpi_ready === 1'b1) : (if64.pcpi_ready === 1'b1);
    end
    #1;
    if (!seen) begin
      n_vec++;
      fail_line("ready_timeout", sel, 64'd0, 64'd1);
      if (sel == 0) exp_q0.delete();
      else exp_q1.delete();
    end
    infl[sel] = 1'b0;
    if (!hold) idle();
    @(negedge clk);
    #1;
    idle();
    @(negedge clk);
    #1;
  endtask

  task automatic run_rand(input int sel);
    logic [2:0]  f3;
    logic [63:0] a, b;
    int          xlen;
    xlen = (sel == 0) ? 32 : 64;
    f3 = 3'($urandom_range(0, 7));
    a  = rand_opnd(xlen);
    b  = rand_opnd(xlen);
    run_op(sel, f3, a, b, 1'($urandom_range(0, 1)), model(xlen, f3, a, b));
  endtask

  task automatic check_zero32(input string what);
    n_vec++;
    if ({if32.pcpi_ready, if32.pcpi_wr, if32.pcpi_wait} !== 3'b000 || if32.pcpi_rd !== 32'd0)
      fail_line(what, 0, {29'd0, if32.pcpi_ready, if32.pcpi_wr, if32.pcpi_wait}, 64'd0);
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    drive(0, 1'b0, 32'd0, 64'd0, 64'd0);
    drive(1, 1'b0, 32'd0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check_zero32("reset_state");
    #1 reset = 1'b0;
    @(negedge clk);
    #1;

    // Directed vectors, XLEN=32.
    run_op(0, 3'd0, 64'h7,         64'hFFFF_FFFD, 1'b0, 64'hFFFF_FFEB);
    run_op(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 1'b0, 64'h4000_0000);
    run_op(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE);
    run_op(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF);
    run_op(0, 3'd4, 64'hFFFF_FFF9, 64'h2,         1'b0, 64'hFFFF_FFFD);
    run_op(0, 3'd6, 64'hFFFF_FFF9, 64'h2,         1'b0, 64'hFFFF_FFFF);
    run_op(0, 3'd5, 64'd100,       64'd7,         1'b0, 64'd14);
    run_op(0, 3'd7, 64'd100,       64'd7,         1'b0, 64'd2);
    run_op(0, 3'd5, 64'd5,         64'd0,         1'b0, 64'hFFFF_FFFF);
    run_op(0, 3'd6, 64'd5,         64'd0,         1'b0, 64'd5);
    run_op(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 64'h8000_0000);
    run_op(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 64'd0);

    // Valid held through the cycle after DONE, then a fresh MUL at L+2.
    run_op(0, 3'd0, 64'd6, 64'd7, 1'b1, 64'd42);
    run_op(0, 3'd3, 64'd3, 64'd5, 1'b0, 64'd0);

    // ADD encoding held valid for 10 cycles: must be ignored.
    drive(0, 1'b1, {7'b0000000, 5'd3, 5'd2, 3'd0, 5'd1, 7'b0110011}, 64'd1, 64'd2);
    repeat (10) @(negedge clk);
    #1 idle();
    @(negedge clk);
    #1;

    // Reset during a DIV: no ready, outputs clear, then a normal DIVU.
    c0 = cyc;
    infl_start[0] = c0;
    infl_due[0]   = c0 + 33;
    infl[0]       = 1'b1;
    drive(0, 1'b1, m_insn(3'd4), 64'd100, 64'd7);
    repeat (10) @(negedge clk);
    #1;
    reset     = 1'b1;
    infl[0]   = 1'b0;
    idle();
    @(negedge clk);
    check_zero32("reset_abort");
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    run_op(0, 3'd5, 64'd9, 64'd3, 1'b0, 64'd3);

    for (int i = 0; i < 40; i++) run_rand(0);

    // Directed multiply vectors, XLEN=64, MUL_STEP=1.
    run_op(1, 3'd0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
           64'h4000_0000_0000_0000);
    run_op(1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE);
    run_op(1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 12; i++) run_rand(1);

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q0.size() + exp_q1.size() != 0)
      fail_line("leftover_expect", 0, 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/raifes_pcpi_muldiv.md
Name: raifes_pcpi_muldiv

Overview:
- Parametrised RV32M/RV64M multiply/divide coprocessor on the PCPI bus. It is the successor to the fixed 32-bit mul/div unit.
- Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU at width XLEN.
- Multiplier throughput is configurable via a radix-2^MUL_STEP shift-add datapath. The divider is restoring, one quotient bit per cycle.
- Adds full RISC-V divide-by-zero and signed-overflow semantics, and a re-accept guard after completion.

Parameters:
- XLEN, 32, operand/result width. Legal values: 32, 64.
- MUL_STEP, 8, multiplier bits retired per cycle. Must divide XLEN; legal values 1, 2, 4, 8, 16, 32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pcpi_valid  in  1  core presents an instruction
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  XLEN  operand 1
- pcpi_rs2  in  XLEN  operand 2
- pcpi_wr  out  1  write rd; high only together with pcpi_ready
- pcpi_rd  out  XLEN  result; 0 whenever pcpi_ready=0
- pcpi_wait  out  1  busy, hold pipeline
- pcpi_ready  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous, active-high reset; clock clk. Reset forces state IDLE and clears all datapath registers and the guard flag. All outputs read 0 in the cycle after reset is sampled. Reset mid-operation aborts the operation; no ready pulse is issued.
- Decode: an instruction is accepted only if opcode=0110011 and funct7=0000001. funct3 selects 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Non-M instructions: ignored; wait, ready and wr stay 0.
- State machine: IDLE, MUL, DIV, DONE.
- IDLE:
  - If pcpi_valid=1, decode hits and guard=0 (accept edge, cycle 0): latch insn, rs1, rs2, compute operand magnitudes and result sign.
  - Next state is MUL; or DIV; or DONE directly for divide special cases.
  - pcpi_valid is ignored in every state other than IDLE.
- MUL:
  - Runs for N=XLEN/MUL_STEP cycles on magnitudes.
  - Each cycle: acc += (|a| * next MUL_STEP bits of |b|) << (k*MUL_STEP), where k is the step counter, 0..N-1.
  - Then goes to DONE.
  - Signedness: MUL/MULH treat rs1 and rs2 as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - Final 2*XLEN product is conditionally two's-complement negated.
  - MUL returns bits [XLEN-1:0]; the MULH* variants return [2XLEN-1:XLEN].
  - Result must equal the exact 2*XLEN product for all inputs, including the most negative operand.
- DIV:
  - Restoring division on magnitudes, XLEN cycles, MSB first, then DONE.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1). Signed forms only.
- Divide special cases (detected at accept, go straight to DONE):
  - rs2=0: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = most negative value, rs2 = all ones): quotient = rs1; remainder = 0.
- pcpi_wait = 1 exactly while state is MUL or DIV.
- DONE: pcpi_ready=1, pcpi_wr=1, pcpi_rd=result for exactly one cycle; wait=0. Sets guard=1; next state is IDLE.
- Guard: blocks acceptance for the first IDLE cycle after DONE, because the core's registered pcpi_valid lags by one cycle. It clears after that cycle.
- Latency, counting the accept edge as cycle 0; ready is high in cycle L:
  - MUL*: L = N+1. Default is 5.
  - DIV*/REM* normal case: L = XLEN+1. Default is 33.
  - Divide special cases: L = 1.
- Back-to-back: the earliest next accept is cycle L+2.

Test Plan:
- XLEN=32, MUL_STEP=8:
  - MUL 7 * 0xFFFFFFFD -> rd=0xFFFFFFEB, ready at cycle 5, wait high cycles 1-4.
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Ready at cycle 33 for each.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Ready at cycle 1 for each, with wait never asserted.
- ADD encoding (funct7=0) held valid for 10 cycles -> wait, ready and wr all 0 throughout.
- pcpi_valid held high through the cycle after DONE -> no second ready pulse. Then a new MUL asserted at cycle L+2 -> accepted.
- Reset asserted at cycle 10 of a DIV -> all outputs 0 at cycle 11 and no ready pulse; a following DIVU 9/3 -> 3.
- Repeat the multiply vectors with XLEN=64, MUL_STEP=1: MULHU all-ones*all-ones -> 0xFFFFFFFFFFFFFFFE, ready at cycle 65.
